frame_mem_arbiter: RTL and testbench

Two-client arbiter in front of one `memory_list` frame buffer. It multiplexes a capture-side client (A) and a processing-side client (B) onto the memory's write and read ports, one access per cycle. Arbitration is round-robin with bounded bursts. The block drives registered memory commands and steers the returning read data, with a valid strobe, to the client that issued the read.

---
 rtl/frame_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: two-client round-robin arbiter with bounded bursts
// in front of a single-port-pair frame memory; steers read returns.
module frame_mem_arbiter #(
  parameter int mem_width   = 24,
  parameter int address_len = 17,
  parameter int max_burst   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [address_len-1:0] a_addr,
  input  logic [mem_width-1:0]   a_wdata,
  output logic                   a_gnt,
  output logic                   a_rvalid,
  output logic [mem_width-1:0]   a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [address_len-1:0] b_addr,
  input  logic [mem_width-1:0]   b_wdata,
  output logic                   b_gnt,
  output logic                   b_rvalid,
  output logic [mem_width-1:0]   b_rdata,
  output logic                   mem_w_en,
  output logic [address_len-1:0] mem_w_addr,
  output logic [mem_width-1:0]   mem_w_data,
  output logic                   mem_r_en,
  output logic [address_len-1:0] mem_r_addr,
  input  logic [mem_width-1:0]   mem_r_data
);

  localparam int BW = $clog2(max_burst + 1);
  localparam logic [BW-1:0] BMAX = BW'(max_burst);

  typedef enum logic [1:0] {
    O_NONE,
    O_A,
    O_B
  } owner_t;

  owner_t          owner;
  owner_t          win;
  logic [BW-1:0]   burst_cnt;
  logic            last_b;
  logic            pick_a;
  logic            pick_b;
  logic            acc;
  logic            acc_we;
  logic [address_len-1:0] acc_addr;
  logic [mem_width-1:0]   acc_wdata;
  logic            t1_v;
  logic            t1_b;
  logic            t2_v;
  logic            t2_b;

  // winner select: lone requester wins, else burst limit, else not-last
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    unique case (1'b1)
      (a_req && !b_req): pick_a = 1'b1;
      (!a_req && b_req): pick_b = 1'b1;
      (a_req && b_req): begin
        unique case (owner)
          O_A: begin
            if (burst_cnt < BMAX) pick_a = 1'b1;
            else pick_b = 1'b1;
          end
          O_B: begin
            if (burst_cnt < BMAX) pick_b = 1'b1;
            else pick_a = 1'b1;
          end
          default: begin
            if (last_b) pick_a = 1'b1;
            else pick_b = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign a_gnt     = pick_a;
  assign b_gnt     = pick_b;
  assign acc       = pick_a | pick_b;
  assign win       = pick_b ? O_B : O_A;
  assign acc_we    = pick_b ? b_we    : a_we;
  assign acc_addr  = pick_b ? b_addr  : a_addr;
  assign acc_wdata = pick_b ? b_wdata : a_wdata;

  // ownership and burst tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= O_NONE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else if (acc) begin
      if (win == owner) begin
        if (burst_cnt != BMAX) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        owner     <= win;
        burst_cnt <= BW'(1);
      end
      last_b <= pick_b;
    end else begin
      owner     <= O_NONE;
      burst_cnt <= '0;
    end
  end

  // registered memory command for the accepted access
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_r_en   <= 1'b0;
      mem_r_addr <= '0;
    end else begin
      mem_w_en <= acc & acc_we;
      mem_r_en <= acc & ~acc_we;
      if (acc && acc_we) begin
        mem_w_addr <= acc_addr;
        mem_w_data <= acc_wdata;
      end
      if (acc && !acc_we) mem_r_addr <= acc_addr;
    end
  end

  // read tag pipeline: stage 1 tracks the command, stage 2 the data
  always_ff @(posedge clk) begin
    if (reset) begin
      t1_v <= 1'b0;
      t1_b <= 1'b0;
      t2_v <= 1'b0;
      t2_b <= 1'b0;
    end else begin
      t1_v <= acc & ~acc_we;
      t1_b <= pick_b;
      t2_v <= t1_v;
      t2_b <= t1_b;
    end
  end

  assign a_rvalid = t2_v & ~t2_b;
  assign b_rvalid = t2_v & t2_b;
  assign a_rdata  = mem_r_data;
  assign b_rdata  = mem_r_data;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed stimulus, queue scoreboard on read
// returns, behavioural frame memory with one-cycle registered read.
module tb_frame_mem_arbiter;

  localparam int W  = 24;
  localparam int AL = 17;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AL-1:0] a_addr = '0;
  logic [W-1:0]  a_wdata = '0;
  logic          a_gnt, a_rvalid;
  logic [W-1:0]  a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AL-1:0] b_addr = '0;
  logic [W-1:0]  b_wdata = '0;
  logic          b_gnt, b_rvalid;
  logic [W-1:0]  b_rdata;
  logic          mem_w_en, mem_r_en;
  logic [AL-1:0] mem_w_addr, mem_r_addr;
  logic [W-1:0]  mem_w_data;
  logic [W-1:0]  mem_r_data = '0;

  logic [W-1:0]  mem [0:1023];

  typedef struct packed {
    logic         id;
    logic [W-1:0] d;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;
  logic [W-1:0] a_exp = '0;
  logic [W-1:0] b_exp = '0;

  always #5 clk = ~clk;

  frame_mem_arbiter #(
    .mem_width(W),
    .address_len(AL),
    .max_burst(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_req(a_req),
    .a_we(a_we),
    .a_addr(a_addr),
    .a_wdata(a_wdata),
    .a_gnt(a_gnt),
    .a_rvalid(a_rvalid),
    .a_rdata(a_rdata),
    .b_req(b_req),
    .b_we(b_we),
    .b_addr(b_addr),
    .b_wdata(b_wdata),
    .b_gnt(b_gnt),
    .b_rvalid(b_rvalid),
    .b_rdata(b_rdata),
    .mem_w_en(mem_w_en),
    .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_w_en) mem[mem_w_addr[9:0]] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_addr[9:0]];
  end

  // monitor: pop expected returns whenever a client sees rvalid
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (mem_w_en && mem_r_en)
        $display("FAIL both_en: w_en=%0b r_en=%0b want not both",
                 mem_w_en, mem_r_en);
      else if (a_rvalid && b_rvalid)
        $display("FAIL both_rvalid: a=%0b b=%0b want not both",
                 a_rvalid, b_rvalid);
      else pass_cnt++;
      if (a_rvalid || b_rvalid) begin
        total++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_rvalid: a=%0b b=%0b cyc=%0d",
                   a_rvalid, b_rvalid, cyc);
        end else begin
          exp_t e;
          logic [W-1:0] d;
          e = sbq.pop_front();
          d = b_rvalid ? b_rdata : a_rdata;
          if (b_rvalid !== e.id || d !== e.d || cyc != e.due)
            $display("FAIL rdata: id=%0b data=%0h cyc=%0d want id=%0b data=%0h cyc=%0d",
                     b_rvalid, d, cyc, e.id, e.d, e.due);
          else pass_cnt++;
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        exp_t e;
        total++;
        e = sbq.pop_front();
        $display("FAIL missing_rvalid: none by cyc=%0d want id=%0b data=%0h at %0d",
                 cyc, e.id, e.d, e.due);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic set_a(input logic r, input logic w,
                       input int ad, input int wd);
    a_req   = r;
    a_we    = w;
    a_addr  = AL'(ad);
    a_wdata = W'(wd);
  endtask

  task automatic set_b(input logic r, input logic w,
                       input int ad, input int wd);
    b_req   = r;
    b_we    = w;
    b_addr  = AL'(ad);
    b_wdata = W'(wd);
  endtask

  // one cycle: check grants, push read expectations, cross the edge
  task automatic step(input logic ega, input logic egb);
    exp_t e;
    @(negedge clk);
    chk("a_gnt", 32'(a_gnt), 32'(ega));
    chk("b_gnt", 32'(b_gnt), 32'(egb));
    if (ega && !a_we) begin
      e.id = 1'b0; e.d = a_exp; e.due = cyc + 2;
      sbq.push_back(e);
    end
    if (egb && !b_we) begin
      e.id = 1'b1; e.d = b_exp; e.due = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b0, 1'b0, 0, 0);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_rdata", 32'(a_rdata), 32'd0);

    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, i, 'h10 + i);
      step(1'b1, 1'b0);
      chk("cmd_w_en", 32'(mem_w_en), 32'd1);
      chk("cmd_w_addr", 32'(mem_w_addr), 32'(i));
      chk("cmd_w_data", 32'(mem_w_data), 32'('h10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, i, 0);
      a_exp = W'('h10 + i);
      step(1'b1, 1'b0);
      chk("cmd_r_en", 32'(mem_r_en), 32'd1);
      chk("cmd_w_off", 32'(mem_w_en), 32'd0);
    end
    idle(4);

    do_reset();
    set_a(1'b1, 1'b1, 300, 1);
    set_b(1'b1, 1'b1, 400, 2);
    for (int i = 0; i < 40; i++) begin
      if (i < 16 || i >= 32) step(1'b1, 1'b0);
      else step(1'b0, 1'b1);
    end
    idle(2);

    set_a(1'b1, 1'b1, 5, 'h55);
    step(1'b1, 1'b0);
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b1, 1'b1, 9, 'h99);
    step(1'b0, 1'b1);
    a_exp = W'('h55);
    b_exp = W'('h99);
    set_b(1'b0, 1'b0, 0, 0);
    set_a(1'b1, 1'b0, 5, 0);
    step(1'b1, 1'b0);
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b1, 1'b0, 9, 0);
    step(1'b0, 1'b1);
    set_b(1'b0, 1'b0, 0, 0);
    set_a(1'b1, 1'b0, 5, 0);
    step(1'b1, 1'b0);
    set_b(1'b1, 1'b0, 9, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    set_a(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1);
    idle(4);

    set_b(1'b1, 1'b1, 7, 'hABC);
    step(1'b0, 1'b1);
    set_b(1'b0, 1'b0, 0, 0);
    set_a(1'b1, 1'b0, 7, 0);
    a_exp = W'('hABC);
    step(1'b1, 1'b0);
    idle(4);

    set_a(1'b1, 1'b0, 5, 0);
    a_exp = W'('h55);
    step(1'b1, 1'b0);
    void'(sbq.pop_back());
    set_a(1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_r_en", 32'(mem_r_en), 32'd0);
    chk("mid_rst_a_rvalid", 32'(a_rvalid), 32'd0);
    idle(3);
    set_a(1'b1, 1'b1, 500, 3);
    set_b(1'b1, 1'b1, 600, 4);
    step(1'b1, 1'b0);
    idle(1);

    set_a(1'b1, 1'b1, 700, 5);
    repeat (20) step(1'b1, 1'b0);
    set_b(1'b1, 1'b1, 800, 6);
    step(1'b0, 1'b1);
    idle(4);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
